// File: rtl/ctrl_cmd_arbiter_if.sv
// Request/grant handshakes and the issued command bus of the DDR4 command arbiter.
interface ctrl_cmd_arbiter_if;
    logic        act_req;
    logic [1:0]  act_bg;
    logic [1:0]  act_ba;
    logic [14:0] act_row;
    logic        cas_req;
    logic        cas_wr;
    logic [1:0]  cas_bg;
    logic [1:0]  cas_ba;
    logic [9:0]  cas_col;
    logic        pre_req;
    logic [1:0]  pre_bg;
    logic [1:0]  pre_ba;
    logic        ref_req;

    logic        act_gnt;
    logic        cas_gnt;
    logic        pre_gnt;
    logic        ref_gnt;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [14:0] cmd_addr;
    logic        ref_busy;

    modport master (
        output act_req, act_bg, act_ba, act_row,
        output cas_req, cas_wr, cas_bg, cas_ba, cas_col,
        output pre_req, pre_bg, pre_ba, ref_req,
        input  act_gnt, cas_gnt, pre_gnt, ref_gnt,
        input  cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr, ref_busy
    );

    modport slave (
        input  act_req, act_bg, act_ba, act_row,
        input  cas_req, cas_wr, cas_bg, cas_ba, cas_col,
        input  pre_req, pre_bg, pre_ba, ref_req,
        output act_gnt, cas_gnt, pre_gnt, ref_gnt,
        output cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr, ref_busy
    );
endinterface

// File: rtl/ctrl_cmd_arbiter.sv
// Single-issue DDR4 command-bus arbiter: REF > PRE > CAS > ACT with rank-level
// tRRD / tFAW / tCCD / tRFC spacing and registered (1-cycle) grant/command outputs.
module ctrl_cmd_arbiter #(
    parameter int unsigned tRRD = 4,
    parameter int unsigned tFAW = 16,
    parameter int unsigned tCCD = 4,
    parameter int unsigned tRFC = 32
) (
    input  logic             CK_t,
    input  logic             reset,
    ctrl_cmd_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2((tRFC > tFAW) ? tRFC : tFAW) + 1;

    typedef enum logic { ARB, REF_WAIT } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rfc_cnt;
    logic [CNT_W-1:0] ccd_cnt;
    logic [CNT_W-1:0] rrd_cnt;
    logic [CNT_W-1:0] faw_cnt [4];

    logic             rfc_last;
    logic             arb_en;
    logic             faw_free;
    logic [1:0]       faw_sel;
    logic             win_ref, win_pre, win_cas, win_act;
    logic [2:0]       nxt_type;
    logic [1:0]       nxt_bg, nxt_ba;
    logic [14:0]      nxt_addr;

    assign rfc_last = (state == REF_WAIT) && (rfc_cnt == CNT_W'(tRFC - 1));
    // The final blackout cycle already arbitrates so the next command lands at REF + tRFC.
    assign arb_en   = (state == ARB) || rfc_last;

    always_comb begin
        faw_free = 1'b0;
        faw_sel  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!faw_free && faw_cnt[i] == '0) begin
                faw_free = 1'b1;
                faw_sel  = 2'(i);
            end
        end
    end

    always_comb begin
        win_ref  = 1'b0;
        win_pre  = 1'b0;
        win_cas  = 1'b0;
        win_act  = 1'b0;
        nxt_type = 3'd0;
        nxt_bg   = '0;
        nxt_ba   = '0;
        nxt_addr = '0;
        state_nxt = state;
        // A requester currently holding its grant is masked while it drops req.
        if (arb_en) begin
            if (bus.ref_req && !bus.ref_gnt) begin
                win_ref  = 1'b1;
                nxt_type = 3'd5;
            end else if (bus.pre_req && !bus.pre_gnt) begin
                win_pre  = 1'b1;
                nxt_type = 3'd4;
                nxt_bg   = bus.pre_bg;
                nxt_ba   = bus.pre_ba;
            end else if (bus.cas_req && !bus.cas_gnt && ccd_cnt == '0) begin
                win_cas  = 1'b1;
                nxt_type = bus.cas_wr ? 3'd3 : 3'd2;
                nxt_bg   = bus.cas_bg;
                nxt_ba   = bus.cas_ba;
                nxt_addr = {5'd0, bus.cas_col};
            end else if (bus.act_req && !bus.act_gnt && rrd_cnt == '0 && faw_free) begin
                win_act  = 1'b1;
                nxt_type = 3'd1;
                nxt_bg   = bus.act_bg;
                nxt_ba   = bus.act_ba;
                nxt_addr = bus.act_row;
            end
        end
        case (state)
            ARB:      if (win_ref) state_nxt = REF_WAIT;
            REF_WAIT: if (rfc_last) state_nxt = win_ref ? REF_WAIT : ARB;
            default:  state_nxt = ARB;
        endcase
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state   <= ARB;
            rfc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (win_ref)
                rfc_cnt <= '0;
            else if (state == REF_WAIT)
                rfc_cnt <= rfc_cnt + 1'b1;
        end
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            ccd_cnt <= '0;
            rrd_cnt <= '0;
            for (int unsigned i = 0; i < 4; i++) faw_cnt[i] <= '0;
        end else begin
            ccd_cnt <= win_cas ? CNT_W'(tCCD - 1) : ((ccd_cnt != '0) ? ccd_cnt - 1'b1 : '0);
            rrd_cnt <= win_act ? CNT_W'(tRRD - 1) : ((rrd_cnt != '0) ? rrd_cnt - 1'b1 : '0);
            for (int unsigned i = 0; i < 4; i++) begin
                if (win_act && faw_sel == 2'(i))
                    faw_cnt[i] <= CNT_W'(tFAW - 1);
                else if (faw_cnt[i] != '0)
                    faw_cnt[i] <= faw_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            bus.act_gnt   <= 1'b0;
            bus.cas_gnt   <= 1'b0;
            bus.pre_gnt   <= 1'b0;
            bus.ref_gnt   <= 1'b0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_type  <= '0;
            bus.cmd_bg    <= '0;
            bus.cmd_ba    <= '0;
            bus.cmd_addr  <= '0;
            bus.ref_busy  <= 1'b0;
        end else begin
            bus.act_gnt   <= win_act;
            bus.cas_gnt   <= win_cas;
            bus.pre_gnt   <= win_pre;
            bus.ref_gnt   <= win_ref;
            bus.cmd_valid <= win_ref | win_pre | win_cas | win_act;
            bus.cmd_type  <= nxt_type;
            bus.cmd_bg    <= nxt_bg;
            bus.cmd_ba    <= nxt_ba;
            bus.cmd_addr  <= nxt_addr;
            bus.ref_busy  <= (state == REF_WAIT) && !rfc_last;
        end
    end
endmodule

// File: tb/tb_ctrl_cmd_arbiter.sv
// Directed bench for ctrl_cmd_arbiter: single-shot vector table plus multi-cycle sequences.
module tb_ctrl_cmd_arbiter;
    logic CK_t = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 CK_t = ~CK_t;

    ctrl_cmd_arbiter_if bus();

    ctrl_cmd_arbiter #(.tRRD(4), .tFAW(16), .tCCD(4), .tRFC(32)) dut (
        .CK_t (CK_t),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  req;      // {ref, pre, cas, act}
        logic        wr;
        logic [3:0]  exp_gnt;  // {ref, pre, cas, act}
        logic [2:0]  exp_type;
        logic [1:0]  exp_bg;
        logic [1:0]  exp_ba;
        logic [14:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK_t);
        #1;
    endtask

    // Fixed per-requester targets: ACT bg1/ba2/row 1ABC, CAS bg2/ba1/col 3A5, PRE bg3/ba0.
    task automatic set_reqs(input logic [3:0] r, input logic wr);
        bus.ref_req = r[3];
        bus.pre_req = r[2];
        bus.cas_req = r[1];
        bus.act_req = r[0];
        bus.act_bg  = 2'd1;
        bus.act_ba  = 2'd2;
        bus.act_row = 15'h1ABC;
        bus.cas_wr  = wr;
        bus.cas_bg  = 2'd2;
        bus.cas_ba  = 2'd1;
        bus.cas_col = 10'h3A5;
        bus.pre_bg  = 2'd3;
        bus.pre_ba  = 2'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_reqs(4'b0000, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [27:0] outs();
        return {bus.ref_gnt, bus.pre_gnt, bus.cas_gnt, bus.act_gnt, bus.cmd_valid,
                bus.cmd_type, bus.cmd_bg, bus.cmd_ba, bus.cmd_addr, bus.ref_busy};
    endfunction

    initial begin
        int n;
        int busy;
        int exp_cyc [3];
        logic [2:0] exp_ty [3];

        vecs.push_back('{4'b0001, 1'b0, 4'b0001, 3'd1, 2'd1, 2'd2, 15'h1ABC});
        vecs.push_back('{4'b0010, 1'b0, 4'b0010, 3'd2, 2'd2, 2'd1, 15'h03A5});
        vecs.push_back('{4'b0010, 1'b1, 4'b0010, 3'd3, 2'd2, 2'd1, 15'h03A5});
        vecs.push_back('{4'b0100, 1'b0, 4'b0100, 3'd4, 2'd3, 2'd0, 15'h0000});
        vecs.push_back('{4'b1000, 1'b0, 4'b1000, 3'd5, 2'd0, 2'd0, 15'h0000});
        vecs.push_back('{4'b0111, 1'b1, 4'b0100, 3'd4, 2'd3, 2'd0, 15'h0000});
        vecs.push_back('{4'b0011, 1'b1, 4'b0010, 3'd3, 2'd2, 2'd1, 15'h03A5});
        vecs.push_back('{4'b1100, 1'b0, 4'b1000, 3'd5, 2'd0, 2'd0, 15'h0000});
        vecs.push_back('{4'b1111, 1'b0, 4'b1000, 3'd5, 2'd0, 2'd0, 15'h0000});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 3'd0, 2'd0, 2'd0, 15'h0000});

        // Reset holds every output low even with all requests asserted.
        reset = 1'b1;
        set_reqs(4'b1111, 1'b1);
        tick();
        check("reset_outs_1", 32'(outs()), 32'd0);
        tick();
        check("reset_outs_2", 32'(outs()), 32'd0);

        foreach (vecs[i]) begin
            do_reset();
            set_reqs(vecs[i].req, vecs[i].wr);
            tick();
            check($sformatf("v%0d_gnt", i), 32'({bus.ref_gnt, bus.pre_gnt, bus.cas_gnt, bus.act_gnt}),
                  32'(vecs[i].exp_gnt));
            check($sformatf("v%0d_valid", i), 32'(bus.cmd_valid), 32'(vecs[i].exp_gnt != 4'b0000));
            check($sformatf("v%0d_type", i), 32'(bus.cmd_type), 32'(vecs[i].exp_type));
            check($sformatf("v%0d_bg", i), 32'(bus.cmd_bg), 32'(vecs[i].exp_bg));
            check($sformatf("v%0d_ba", i), 32'(bus.cmd_ba), 32'(vecs[i].exp_ba));
            check($sformatf("v%0d_addr", i), 32'(bus.cmd_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_busy", i), 32'(bus.ref_busy), 32'd0);
        end

        // Single ACT with late drop: exactly one grant.
        do_reset();
        set_reqs(4'b0001, 1'b0);
        tick();
        check("single_act_gnt", 32'(bus.act_gnt), 32'd1);
        check("single_act_addr", 32'(bus.cmd_addr), 32'h1ABC);
        tick();
        set_reqs(4'b0000, 1'b0);
        check("single_act_late_drop", 32'(outs()), 32'd0);
        tick();
        check("single_act_idle", 32'(outs()), 32'd0);

        // tRRD / tFAW: continuous ACT request.
        do_reset();
        set_reqs(4'b0001, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            tick();
            check($sformatf("rrd_faw_c%0d", c), 32'(bus.act_gnt), 32'(c % 4 == 1));
        end
        set_reqs(4'b0000, 1'b0);

        // tCCD: RD, WR, RD with the next request presented right after each grant.
        exp_cyc = '{1, 5, 9};
        exp_ty  = '{3'd2, 3'd3, 3'd2};
        do_reset();
        set_reqs(4'b0010, 1'b0);
        n = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (bus.cas_gnt) begin
                if (n < 3) begin
                    check($sformatf("ccd_cycle_%0d", n), 32'(c), 32'(exp_cyc[n]));
                    check($sformatf("ccd_type_%0d", n), 32'(bus.cmd_type), 32'(exp_ty[n]));
                end
                n++;
                if (n == 1) set_reqs(4'b0010, 1'b1);
                else if (n == 2) set_reqs(4'b0010, 1'b0);
                else set_reqs(4'b0000, 1'b0);
            end
        end
        check("ccd_count", 32'(n), 32'd3);

        // Priority: PRE, CAS, ACT in consecutive cycles.
        do_reset();
        set_reqs(4'b0111, 1'b0);
        tick();
        check("prio_c1_type", 32'(bus.cmd_type), 32'd4);
        set_reqs(4'b0011, 1'b0);
        tick();
        check("prio_c2_type", 32'(bus.cmd_type), 32'd2);
        set_reqs(4'b0001, 1'b0);
        tick();
        check("prio_c3_type", 32'(bus.cmd_type), 32'd1);
        set_reqs(4'b0000, 1'b0);
        tick();
        check("prio_c4_idle", 32'(bus.cmd_valid), 32'd0);

        // REF blackout: ACT exactly 32 cycles after REF.
        do_reset();
        set_reqs(4'b1001, 1'b0);
        tick();
        check("ref_c1_gnt", 32'(bus.ref_gnt), 32'd1);
        check("ref_c1_type", 32'(bus.cmd_type), 32'd5);
        check("ref_c1_busy", 32'(bus.ref_busy), 32'd0);
        set_reqs(4'b0001, 1'b0);
        busy = 0;
        for (int c = 2; c <= 34; c++) begin
            tick();
            busy += int'(bus.ref_busy);
            check($sformatf("ref_act_c%0d", c), 32'(bus.cmd_valid && bus.act_gnt), 32'(c == 33));
        end
        check("ref_busy_cycles", 32'(busy), 32'd31);
        set_reqs(4'b0000, 1'b0);

        // Reset in the middle of the blackout.
        do_reset();
        set_reqs(4'b1001, 1'b0);
        tick();
        check("rst_mid_ref_gnt", 32'(bus.ref_gnt), 32'd1);
        set_reqs(4'b0001, 1'b0);
        repeat (10) tick();
        check("rst_mid_busy_before", 32'(bus.ref_busy), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_outs", 32'(outs()), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_mid_act_gnt", 32'(bus.act_gnt), 32'd1);
        check("rst_mid_act_type", 32'(bus.cmd_type), 32'd1);
        set_reqs(4'b0000, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
